// File: rtl/refresh_poll_master.sv
// rtl/refresh_poll_master.sv - Avalon-MM poller for the HDMI refresh status PIO
//
// Reads bit 0 of the refresh PIO (s1, word address 0, read latency 1) once
// every POLL_DIV cycles. It produces a registered level, a one-cycle
// rising-edge pulse and a wrapping count of those pulses.
//
// Optional feature macro: REFRESH_POLL_WAITREQ_EN
//   defined   : avm_read is held while avm_waitrequest=1. The poll period
//               stretches by the stall cycles.
//   undefined : avm_waitrequest is ignored. Every read is accepted in one cycle.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   enable          in   polling enable (level)
//   count_clr       in   synchronous clear of frame_count, wins over increment
//   avm_address     out  slave word address, constant 0
//   avm_read        out  read command (registered)
//   avm_readdata    in   slave read data, bit 0 used
//   avm_waitrequest in   slave stall (macro build only)
//   refresh_level   out  last sampled bit 0
//   refresh_pulse   out  one-cycle pulse on a sampled 0->1 transition
//   frame_count     out  refresh_pulse events modulo 2^CNT_W

module refresh_poll_master #(
    parameter int POLL_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             count_clr,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic             refresh_level,
    output logic             refresh_pulse,
    output logic [CNT_W-1:0] frame_count
);

    localparam int            CW         = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(POLL_DIV - 2);
    // With POLL_DIV=2 the WAIT state would be zero cycles long.
    localparam bit            SKIP_WAIT  = (POLL_DIV == 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             primed_q, primed_d;
    logic             read_q, read_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             read_accept;

    logic unused_inputs;
    assign unused_inputs = ^{avm_readdata[31:1], avm_waitrequest};

`ifdef REFRESH_POLL_WAITREQ_EN
    assign read_accept = !avm_waitrequest;
`else
    assign read_accept = 1'b1;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            primed_q   <= 1'b0;
            read_q     <= 1'b0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            primed_q   <= primed_d;
            read_q     <= read_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic. The WAIT state lasts POLL_DIV-2 cycles, so READ
    // starts exactly POLL_DIV cycles after the previous READ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_READ;
            end
            ST_READ: begin
                if (read_accept) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!enable)        state_d = ST_IDLE;
                else if (SKIP_WAIT) state_d = ST_READ;
                else                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable)                       state_d = ST_IDLE;
                else if (wait_cnt_q <= CW'(1))     state_d = ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic. avm_read is registered from the next state,
    // so it rises together with entry into READ and has no input path.
    always_comb begin
        read_d     = (state_d == ST_READ);
        wait_cnt_d = wait_cnt_q;
        primed_d   = primed_q;
        level_d    = level_q;
        pulse_d    = 1'b0;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                // The first capture after leaving IDLE only seeds refresh_level.
                if (enable) primed_d = 1'b0;
            end
            ST_CAPTURE: begin
                level_d    = avm_readdata[0];
                pulse_d    = primed_q && avm_readdata[0] && !level_q;
                primed_d   = 1'b1;
                wait_cnt_d = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - CW'(1);
            end
            default: ;
        endcase

        // frame_count moves together with the pulse it counts.
        if (count_clr)    count_d = '0;
        else if (pulse_d) count_d = count_q + CNT_W'(1);
    end

    assign avm_address   = 2'b00;
    assign avm_read      = read_q;
    assign refresh_level = level_q;
    assign refresh_pulse = pulse_q;
    assign frame_count   = count_q;

endmodule

// File: tb/tb_refresh_poll_master.sv
// tb/tb_refresh_poll_master.sv - directed self-checking bench for refresh_poll_master

module tb_refresh_poll_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        count_clr;
    logic        avm_waitrequest;
    logic        pio;
    logic [31:0] rd = '0;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic        refresh_level;
    logic        refresh_pulse;
    logic [3:0]  frame_count;

    logic [1:0]  d2_address;
    logic        d2_read;
    logic        d2_level;
    logic        d2_pulse;
    logic [3:0]  d2_count;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int n;
    int reads;

    always #5 clk = ~clk;

    refresh_poll_master #(.POLL_DIV(8), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .count_clr(count_clr),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(rd),
        .avm_waitrequest(avm_waitrequest), .refresh_level(refresh_level),
        .refresh_pulse(refresh_pulse), .frame_count(frame_count)
    );

    refresh_poll_master #(.POLL_DIV(2), .CNT_W(4)) dut_div2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .count_clr(count_clr),
        .avm_address(d2_address), .avm_read(d2_read), .avm_readdata(rd),
        .avm_waitrequest(1'b0), .refresh_level(d2_level),
        .refresh_pulse(d2_pulse), .frame_count(d2_count)
    );

    // Refresh PIO slave: registered readdata, latency 1. While stalled it
    // returns inverted (invalid) data so an early sample would be visible.
    always @(posedge clk) begin
`ifdef REFRESH_POLL_WAITREQ_EN
        if (avm_read) rd <= avm_waitrequest ? {31'b0, ~pio} : {31'b0, pio};
`else
        if (avm_read) rd <= {31'b0, pio};
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (refresh_pulse === 1'b1) pulse_cnt++;
    endtask

    // Advances at least one cycle, stops on the next cycle with avm_read=1.
    task automatic wait_read(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (avm_read !== 1'b1 && cyc < max);
        if (avm_read !== 1'b1) check("read_timeout", 32'(avm_read), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; count_clr = 1'b0;
        avm_waitrequest = 1'b0; pio = 1'b0;
        tick(); tick();
        check("rst_read",  32'(avm_read), 0);
        check("rst_addr",  32'(avm_address), 0);
        check("rst_level", 32'(refresh_level), 0);
        check("rst_pulse", 32'(refresh_pulse), 0);
        check("rst_count", 32'(frame_count), 0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        check("idle_read", 32'(avm_read), 0);

        // Poll period with PIO held at 0.
        enable = 1'b1;
        tick();
        check("first_read", 32'(avm_read), 1);
        check("div2_read0", 32'(d2_read), 1);
        tick();
        check("read_width", 32'(avm_read), 0);
        check("div2_gap",   32'(d2_read), 0);
        tick();
        check("div2_read1", 32'(d2_read), 1);
        wait_read(20, n);
        check("period0", 32'(n), 6);
        wait_read(20, n);
        check("period1", 32'(n), 8);
        wait_read(20, n);
        check("period2", 32'(n), 8);
        check("quiet_pulses", 32'(pulse_cnt), 0);
        check("quiet_count",  32'(frame_count), 0);

        // Single edge, held high.
        pio = 1'b1;
        tick();
        check("edge_level_t1", 32'(refresh_level), 0);
        tick();
        check("edge_level_t2", 32'(refresh_level), 1);
        check("edge_pulse",    32'(refresh_pulse), 1);
        tick();
        check("edge_pulse_end", 32'(refresh_pulse), 0);
        check("edge_count",     32'(frame_count), 1);
        wait_read(20, n);
        wait_read(20, n);
        tick(); tick(); tick();
        check("held_pulses", 32'(pulse_cnt), 1);
        check("held_level",  32'(refresh_level), 1);

        // Reset in the middle of a read drops avm_read immediately.
        wait_read(20, n);
        enable  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_read",  32'(avm_read), 0);
        check("arst_level", 32'(refresh_level), 0);
        check("arst_count", 32'(frame_count), 0);
        tick();
        reset_n = 1'b1;
        tick(); tick();

        // First sample after enable is not an edge (PIO already 1).
        enable = 1'b1;
        tick();
        check("primed_read", 32'(avm_read), 1);
        tick();
        tick();
        check("primed_level", 32'(refresh_level), 1);
        check("primed_pulse", 32'(refresh_pulse), 0);
        tick();
        check("primed_count", 32'(frame_count), 0);

        // Enable dropped in the READ cycle: capture finishes, then idle.
        wait_read(20, n);
        pio = 1'b0;
        enable = 1'b0;
        tick(); tick();
        check("drop_level", 32'(refresh_level), 0);
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (avm_read === 1'b1) reads++;
        end
        check("drop_no_read", 32'(reads), 0);
        enable = 1'b1;
        tick();
        check("reenable_read", 32'(avm_read), 1);

        // 17 edges on a 4-bit counter, with the wrap at 16.
        for (int i = 0; i < 17; i++) begin
            wait_read(20, n);
            pio = 1'b1;
            wait_read(20, n);
            pio = 1'b0;
            check($sformatf("wrap_cnt%0d", i), 32'(frame_count), 32'((i + 1) % 16));
        end
        tick(); tick(); tick();
        check("wrap_final", 32'(frame_count), 1);
        check("wrap_pulses", 32'(pulse_cnt), 18);

        // count_clr coinciding with a pulse wins.
        wait_read(20, n);
        pio = 1'b1;
        tick();
        count_clr = 1'b1;
        tick();
        check("clr_pulse", 32'(refresh_pulse), 1);
        tick();
        count_clr = 1'b0;
        check("clr_count", 32'(frame_count), 0);

        // Waitrequest held high for 3 cycles from the read cycle.
        wait_read(20, n);
        pio = 1'b0;
        avm_waitrequest = 1'b1;
`ifdef REFRESH_POLL_WAITREQ_EN
        tick();
        check("stall_read1", 32'(avm_read), 1);
        tick();
        check("stall_read2", 32'(avm_read), 1);
        tick();
        check("stall_read3", 32'(avm_read), 1);
        avm_waitrequest = 1'b0;
        tick();
        check("stall_read_end", 32'(avm_read), 0);
        check("stall_level_old", 32'(refresh_level), 1);
        tick();
        check("stall_level_new", 32'(refresh_level), 0);
        wait_read(20, n);
        check("stall_period", 32'(n), 6);
`else
        tick();
        check("nostall_read", 32'(avm_read), 0);
        tick();
        check("nostall_level", 32'(refresh_level), 0);
        avm_waitrequest = 1'b0;
        wait_read(20, n);
        check("nostall_period", 32'(n), 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
